i2c_slave_regbank: RTL and testbench

- Fully synchronous, parametrised I2C target for MAX10 designs.
- Receives a fixed-length block of NUM_BYTES bytes from the Arduino master into a shadow buffer.
- Commits the block atomically to a packed output bus and pulses a completion strobe.
- Supports master reads of the committed bytes; SCL/SDA are oversampled on the system clock, with no logic clocked by SCL or SDA.

---
 rtl/i2c_slave_regbank.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: oversampled I2C target that receives a NUM_BYTES block
// into a shadow buffer, commits it atomically to DOUT on STOP (FIN pulse),
// and serves master reads of the committed bytes.
// Optional build macro I2C_REG_PTR_EN: first write byte is a register
// pointer, writes are tracked with a per-byte valid mask, and reads start at
// the last written pointer.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h72,
  parameter int         NUM_BYTES   = 4,
  parameter int         SYNC_STAGES = 3
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   RST,
  input  logic                   SCL,
  inout  wire                    SDA,
  output logic [8*NUM_BYTES-1:0] DOUT,
  output logic                   FIN,
  output logic                   BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_IGNORE
  } state_t;

  localparam logic [4:0] NB      = 5'(NUM_BYTES);
  localparam logic [4:0] NB_LAST = 5'(NUM_BYTES - 1);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  state_t                 state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [4:0]             ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   ack_en_q, ack_en_d;
  logic                   ack_ph_q, ack_ph_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   fin_q, fin_d;
  logic [8*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic [8*NUM_BYTES-1:0] dout_q, dout_d;
`ifdef I2C_REG_PTR_EN
  logic [NUM_BYTES-1:0]   vld_q, vld_d;
  logic [4:0]             regptr_q, regptr_d;
  logic                   ptrbyte_q, ptrbyte_d;
`endif

  logic       scl_s, sda_s;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] rx_byte_s, tx_byte_s;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte_s  = {shift_q[6:0], sda_s};

  assign SDA  = oe_q ? 1'b0 : 1'bz;
  assign DOUT = dout_q;
  assign FIN  = fin_q;
  assign BUSY = busy_q;

  // Shift the raw pins into the synchroniser chains
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA};
  end

  // Select the committed byte addressed by ptr for transmission
  always_comb begin
    tx_byte_s = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (ptr_q == 5'(i)) begin
        tx_byte_s = dout_q[8*i +: 8];
      end else begin
        tx_byte_s = tx_byte_s;
      end
    end
  end

  // Protocol FSM: bus events, address/data shifting, ACK driving and commit
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    ack_en_d = ack_en_q;
    ack_ph_d = ack_ph_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    fin_d    = 1'b0;
    shadow_d = shadow_q;
    dout_d   = dout_q;
`ifdef I2C_REG_PTR_EN
    vld_d     = vld_q;
    regptr_d  = regptr_q;
    ptrbyte_d = ptrbyte_q;
`endif
    if (start_s) begin
      // Repeated START also lands here: discard anything uncommitted.
      state_d  = ST_ADDR;
      bitcnt_d = 4'd0;
      rw_d     = 1'b0;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      shadow_d = '0;
`ifdef I2C_REG_PTR_EN
      ptr_d     = regptr_q;
      vld_d     = '0;
      ptrbyte_d = 1'b1;
`else
      ptr_d    = 5'd0;
`endif
    end else if (stop_s) begin
`ifdef I2C_REG_PTR_EN
      if (busy_q && !rw_q && (|vld_q)) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (vld_q[i]) begin
            dout_d[8*i +: 8] = shadow_q[8*i +: 8];
          end else begin
            dout_d[8*i +: 8] = dout_q[8*i +: 8];
          end
        end
        fin_d = 1'b1;
      end else begin
        fin_d = 1'b0;
      end
`else
      if (busy_q && !rw_q && (ptr_q == NB)) begin
        dout_d = shadow_q;
        fin_d  = 1'b1;
      end else begin
        fin_d = 1'b0;
      end
`endif
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d  = rx_byte_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                state_d  = ST_ADDR_ACK;
                busy_d   = 1'b1;
                rw_d     = rx_byte_s[0];
                ack_ph_d = 1'b0;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!ack_ph_q) begin
              oe_d     = 1'b1;
              ack_ph_d = 1'b1;
            end else if (rw_q) begin
              // The ACK release edge is also where the first read bit goes out.
              oe_d     = ~tx_byte_s[7];
              shift_d  = {tx_byte_s[6:0], 1'b0};
              bitcnt_d = 4'd1;
              state_d  = ST_TX;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RX;
            end
          end else begin
            state_d = ST_ADDR_ACK;
          end
        end
        ST_RX: begin
          if (scl_rise_s) begin
            shift_d  = rx_byte_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              bitcnt_d = 4'd0;
              ack_ph_d = 1'b0;
              state_d  = ST_RX_ACK;
              ack_en_d = 1'b0;
`ifdef I2C_REG_PTR_EN
              if (ptrbyte_q) begin
                ptrbyte_d = 1'b0;
                if (rx_byte_s < 8'(NUM_BYTES)) begin
                  ptr_d    = rx_byte_s[4:0];
                  regptr_d = rx_byte_s[4:0];
                  ack_en_d = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                end
              end else if (ptr_q < NB) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                  if (ptr_q == 5'(i)) begin
                    shadow_d[8*i +: 8] = rx_byte_s;
                    vld_d[i]           = 1'b1;
                  end else begin
                    vld_d[i] = vld_d[i];
                  end
                end
                ptr_d    = ptr_q + 5'd1;
                ack_en_d = 1'b1;
              end else begin
                ack_en_d = 1'b0;
              end
`else
              if (ptr_q < NB) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                  if (ptr_q == 5'(i)) begin
                    shadow_d[8*i +: 8] = rx_byte_s;
                  end else begin
                    shadow_d[8*i +: 8] = shadow_d[8*i +: 8];
                  end
                end
                ptr_d    = ptr_q + 5'd1;
                ack_en_d = 1'b1;
              end else begin
                ack_en_d = 1'b0;
              end
`endif
            end else begin
              state_d = ST_RX;
            end
          end else begin
            state_d = ST_RX;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall_s) begin
            if (!ack_ph_q) begin
              oe_d     = ack_en_q;
              ack_ph_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              state_d  = ST_RX;
            end
          end else begin
            state_d = ST_RX_ACK;
          end
        end
        ST_TX: begin
          if (scl_fall_s) begin
            if (bitcnt_q == 4'd0) begin
              oe_d     = ~tx_byte_s[7];
              shift_d  = {tx_byte_s[6:0], 1'b0};
              bitcnt_d = 4'd1;
            end else if (bitcnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = ST_TX_ACK;
            end else begin
              oe_d     = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
              bitcnt_d = bitcnt_q + 4'd1;
            end
          end else begin
            state_d = ST_TX;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise_s) begin
            if (!sda_s) begin
              ptr_d    = (ptr_q == NB_LAST) ? 5'd0 : (ptr_q + 5'd1);
              bitcnt_d = 4'd0;
              state_d  = ST_TX;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            state_d = ST_TX_ACK;
          end
        end
        ST_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State register with asynchronous reset to the idle, bus-released state
  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 5'd0;
      rw_q       <= 1'b0;
      ack_en_q   <= 1'b0;
      ack_ph_q   <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      shadow_q   <= '0;
      dout_q     <= '0;
`ifdef I2C_REG_PTR_EN
      vld_q      <= '0;
      regptr_q   <= 5'd0;
      ptrbyte_q  <= 1'b0;
`endif
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_en_q   <= ack_en_d;
      ack_ph_q   <= ack_ph_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
`ifdef I2C_REG_PTR_EN
      vld_q      <= vld_d;
      regptr_q   <= regptr_d;
      ptrbyte_q  <= ptrbyte_d;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: bit-banged I2C master on SCL/SDA,
// hand-computed expected values, monitors for FIN pulses and target drive.
module tb_i2c_slave_regbank;

  localparam int Q = 10;  // system clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  wire         sda_w;
  logic [31:0] dout;
  logic        fin;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int fin_cycles = 0;
  int fin_pulses = 0;
  int dut_low_cycles = 0;
  logic fin_prev = 1'b0;

  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #10 clk = ~clk;

  i2c_slave_regbank #(.SLAVE_ADDR(7'h72), .NUM_BYTES(4), .SYNC_STAGES(3)) dut (
    .MAX10_CLK1_50(clk),
    .RST(rst),
    .SCL(scl),
    .SDA(sda_w),
    .DOUT(dout),
    .FIN(fin),
    .BUSY(busy)
  );

  // Count FIN high cycles, FIN pulses and cycles where the target pulls SDA low
  always @(negedge clk) begin
    if (fin) fin_cycles <= fin_cycles + 1;
    if (fin && !fin_prev) fin_pulses <= fin_pulses + 1;
    fin_prev <= fin;
    if ((sda_w === 1'b0) && !m_sda_low) dut_low_cycles <= dut_low_cycles + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_clk(Q);
    scl = 1'b1;     wait_clk(2*Q);
    scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    b = sda_w;        wait_clk(Q);
    scl = 1'b0;       wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~master_ack);
  endtask

  logic [7:0] wr_data [0:5];
  logic [7:0] rd_exp  [0:5];
  logic       ack;
  logic       b;
  logic [7:0] rd;
  int         acks;
  int         snap_fc, snap_fp, snap_low;

  initial begin
    // Reset state
    wait_clk(5);
    check_val("reset_dout_hold", dout, 64'h0);
    rst = 1'b0;
    wait_clk(5);
    check_val("reset_dout", dout, 64'h0);
    check_val("reset_fin", fin, 64'h0);
    check_val("reset_busy", busy, 64'h0);
    check_val("reset_sda", sda_w, 64'h1);

    // Full 4-byte write then STOP commits
    wr_data[0] = 8'hE4; wr_data[1] = 8'h11; wr_data[2] = 8'h22;
    wr_data[3] = 8'h33; wr_data[4] = 8'h44;
    snap_fc = fin_cycles; snap_fp = fin_pulses;
    acks = 0;
    i2c_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(wr_data[i], ack);
      if (ack) acks++;
      if (i == 0) check_val("busy_after_match", busy, 64'h1);
    end
    check_val("t1_dout_before_stop", dout, 64'h0);
    i2c_stop();
    wait_clk(10);
    check_val("t1_acks", acks, 64'd5);
    check_val("t1_dout", dout, 64'h44332211);
    check_val("t1_fin_pulses", fin_pulses - snap_fp, 64'd1);
    check_val("t1_fin_cycles", fin_cycles - snap_fc, 64'd1);
    check_val("t1_busy", busy, 64'h0);

    // Foreign address: target must stay silent
    snap_fc = fin_cycles; snap_low = dut_low_cycles;
    acks = 0;
    i2c_start();
    write_byte(8'hA0, ack);
    if (ack) acks++;
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h5A + 8'(i), ack);
      if (ack) acks++;
    end
    check_val("t2_busy_mid", busy, 64'h0);
    i2c_stop();
    wait_clk(10);
    check_val("t2_acks", acks, 64'd0);
    check_val("t2_sda_driven", dut_low_cycles - snap_low, 64'd0);
    check_val("t2_dout", dout, 64'h44332211);
    check_val("t2_fin", fin_cycles - snap_fc, 64'd0);
    check_val("t2_busy", busy, 64'h0);

    // Short write: no commit
    snap_fc = fin_cycles;
    acks = 0;
    i2c_start();
    write_byte(8'hE4, ack); if (ack) acks++;
    write_byte(8'hAA, ack); if (ack) acks++;
    write_byte(8'hBB, ack); if (ack) acks++;
    i2c_stop();
    wait_clk(10);
    check_val("t3_acks", acks, 64'd3);
    check_val("t3_dout", dout, 64'h44332211);
    check_val("t3_fin", fin_cycles - snap_fc, 64'd0);

    // Read with wrap-around; NACK on the 6th byte
    rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h33;
    rd_exp[3] = 8'h44; rd_exp[4] = 8'h11; rd_exp[5] = 8'h22;
    snap_fc = fin_cycles;
    i2c_start();
    write_byte(8'hE5, ack);
    check_val("t5_addr_ack", ack, 64'h1);
    for (int i = 0; i < 6; i++) begin
      read_byte(i < 5, rd);
      check_val($sformatf("t5_rd%0d", i), rd, rd_exp[i]);
    end
    snap_low = dut_low_cycles;
    recv_bit(b);
    check_val("t5_released_bit", b, 64'h1);
    check_val("t5_released_cnt", dut_low_cycles - snap_low, 64'd0);
    i2c_stop();
    wait_clk(10);
    check_val("t5_dout", dout, 64'h44332211);
    check_val("t5_fin", fin_cycles - snap_fc, 64'd0);

    // Overlong write: 5th data byte NACKed, first four committed
    snap_fp = fin_pulses;
    acks = 0;
    i2c_start();
    write_byte(8'hE4, ack); if (ack) acks++;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i), ack);
      if (ack) acks++;
      if (i == 5) check_val("t4_fifth_nack", ack, 64'h0);
    end
    i2c_stop();
    wait_clk(10);
    check_val("t4_acks", acks, 64'd5);
    check_val("t4_dout", dout, 64'h04030201);
    check_val("t4_fin", fin_pulses - snap_fp, 64'd1);

    // Reset during the ACK clock of the 3rd data byte
    i2c_start();
    write_byte(8'hE4, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    m_sda_low = 1'b0; wait_clk(Q);
    scl = 1'b1;       wait_clk(Q);
    check_val("rst_pre_ack", sda_w, 64'h0);
    rst = 1'b1;
    #2;
    check_val("rst_sda", sda_w, 64'h1);
    check_val("rst_dout", dout, 64'h0);
    check_val("rst_fin", fin, 64'h0);
    check_val("rst_busy", busy, 64'h0);
    wait_clk(5);
    rst = 1'b0;
    wait_clk(Q);

    snap_fp = fin_pulses;
    acks = 0;
    i2c_start();
    write_byte(8'hE4, ack); if (ack) acks++;
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h55, ack);
      if (ack) acks++;
    end
    i2c_stop();
    wait_clk(10);
    check_val("t6_acks", acks, 64'd5);
    check_val("t6_dout", dout, 64'h55555555);
    check_val("t6_fin", fin_pulses - snap_fp, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
